// File: rtl/bpred_btb_bimodal_pkg.sv
// Shared definitions for the BTB + bimodal branch predictor: counter
// encodings, table clear value, BTB entry field offsets, FSM states and
// a clog2 helper usable in constant expressions.
package bpred_btb_bimodal_pkg;

    // 2-bit saturating direction counter encodings
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Value written to every BHT entry during the clear sequence
    localparam ctr_t CTR_INIT = WNT;

    // BTB entry layout {valid, [tag,] target[31:2]}, low field first
    localparam int BTB_TGT_LSB = 0;
    localparam int BTB_TGT_W   = 30;
    localparam int BTB_TAG_LSB = BTB_TGT_LSB + BTB_TGT_W;

    // Table-clear / run sequencing
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    // Ceiling log2, never below 1 so single-entry tables still get an address bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bpred_btb_bimodal_table_ram.sv
// bpred_table_ram: simple dual-port RAM, one write port and one registered
// read port. A read and write to the same address in the same cycle return
// the new data (write-first). Read data holds while re is low.
module bpred_table_ram
    import bpred_btb_bimodal_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port with write-first bypass on address collision
    always_ff @(posedge clk) begin
        if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/bpred_btb_bimodal.sv
// bpred_btb_bimodal: direct-mapped BTB plus bimodal 2-bit counter table with
// a one-cycle registered lookup, a resolve-stage update port and a table
// clear sequence after reset. Optional macro BPRED_TAG_EN stores and
// compares BTB tags; without it a hit only needs the valid bit.
module bpred_btb_bimodal
    import bpred_btb_bimodal_pkg::*;
#(
    parameter int BTB_ENTRIES = 256,
    parameter int BHT_ENTRIES = 512,
    parameter int TAG_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        lu_valid,
    input  logic [31:0] lu_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [1:0]  pred_ctr,
    input  logic        up_valid,
    input  logic [31:0] up_pc,
    input  logic        up_taken,
    input  logic [31:0] up_target,
    input  logic [1:0]  up_ctr
);

    localparam int BTB_IDX_W = clog2(BTB_ENTRIES);
    localparam int BHT_IDX_W = clog2(BHT_ENTRIES);
    localparam int CLR_N     = (BTB_ENTRIES > BHT_ENTRIES) ? BTB_ENTRIES : BHT_ENTRIES;
    localparam int CLR_W     = clog2(CLR_N);
`ifdef BPRED_TAG_EN
    localparam int BTB_W     = 1 + TAG_W + BTB_TGT_W;
`else
    localparam int BTB_W     = 1 + BTB_TGT_W;
    localparam int unused_tag_w = TAG_W;
`endif
    localparam int BTB_VLD   = BTB_W - 1;

    // Saturating counter step toward the resolved direction
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == ST)  ? ST  : c + 2'd1;
        else       return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    fsm_t             state_q, state_d;
    logic [CLR_W-1:0] clr_idx;

    logic                 btb_we, bht_we, lu_re;
    logic [BTB_IDX_W-1:0] btb_waddr;
    logic [BHT_IDX_W-1:0] bht_waddr;
    logic [BTB_W-1:0]     btb_wdata, btb_rd;
    logic [1:0]           bht_wdata, bht_rd;

    logic vld_p0, have_p0, hit_raw;

    logic unused_bits;
    assign unused_bits = ^{lu_pc, up_pc, up_target[1:0]};

    // State register and clear index; reset restarts the clear at entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) clr_idx <= clr_idx + 1'b1;
        end
    end

    // Next state: leave INIT after the last clear write
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && clr_idx == CLR_W'(CLR_N - 1)) state_d = S_RUN;
    end

    // Outputs: clear writes in INIT, update writes and lookups in RUN
    always_comb begin
        ready     = 1'b0;
        lu_re     = 1'b0;
        btb_we    = 1'b0;
        btb_waddr = up_pc[BTB_IDX_W+1:2];
        btb_wdata = '0;
        bht_we    = 1'b0;
        bht_waddr = up_pc[BHT_IDX_W+1:2];
        bht_wdata = CTR_INIT;
        if (state_q == S_INIT) begin
            btb_we    = {1'b0, clr_idx} < (CLR_W+1)'(BTB_ENTRIES);
            btb_waddr = clr_idx[BTB_IDX_W-1:0];
            bht_we    = {1'b0, clr_idx} < (CLR_W+1)'(BHT_ENTRIES);
            bht_waddr = clr_idx[BHT_IDX_W-1:0];
        end else begin
            ready     = 1'b1;
            lu_re     = lu_valid;
            btb_we    = up_valid & up_taken;
`ifdef BPRED_TAG_EN
            btb_wdata = {1'b1, up_pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2], up_target[31:2]};
`else
            btb_wdata = {1'b1, up_target[31:2]};
`endif
            bht_we    = up_valid;
            bht_wdata = ctr_step(up_ctr, up_taken);
        end
    end

    bpred_table_ram #(.WIDTH(BTB_W), .DEPTH(BTB_ENTRIES), .AW(BTB_IDX_W)) u_btb (
        .clk   (clk),
        .we    (btb_we),
        .waddr (btb_waddr),
        .wdata (btb_wdata),
        .re    (lu_re),
        .raddr (lu_pc[BTB_IDX_W+1:2]),
        .rdata (btb_rd)
    );

    bpred_table_ram #(.WIDTH(2), .DEPTH(BHT_ENTRIES), .AW(BHT_IDX_W)) u_bht (
        .clk   (clk),
        .we    (bht_we),
        .waddr (bht_waddr),
        .wdata (bht_wdata),
        .re    (lu_re),
        .raddr (lu_pc[BHT_IDX_W+1:2]),
        .rdata (bht_rd)
    );

    // Stage p0 control: result valid strobe and "any lookup since reset" flag
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            have_p0 <= 1'b0;
        end else begin
            vld_p0 <= lu_re;
            if (lu_re) have_p0 <= 1'b1;
        end
    end

`ifdef BPRED_TAG_EN
    logic [TAG_W-1:0] lu_tag_p0;

    // Stage p0 data: lookup tag, held alongside the RAM read data
    always_ff @(posedge clk) begin
        if (lu_re) lu_tag_p0 <= lu_pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2];
    end

    assign hit_raw = btb_rd[BTB_VLD] & (btb_rd[BTB_TAG_LSB +: TAG_W] == lu_tag_p0);
`else
    assign hit_raw = btb_rd[BTB_VLD];
`endif

    // Results read as zero until the first lookup after reset
    assign pred_valid  = vld_p0;
    assign pred_hit    = have_p0 & hit_raw;
    assign pred_taken  = pred_hit & pred_ctr[1];
    assign pred_target = have_p0 ? {btb_rd[BTB_TGT_LSB +: BTB_TGT_W], 2'b00} : 32'd0;
    assign pred_ctr    = have_p0 ? bht_rd : 2'b00;

endmodule

// File: tb/tb_bpred_btb_bimodal.sv
// Self-checking bench for bpred_btb_bimodal with default depths. A plain
// array model of both tables predicts every lookup result.
module tb_bpred_btb_bimodal;

    localparam int BTB_N = 256;
    localparam int BHT_N = 512;
    localparam int TAGW  = 20;

    logic        clk = 1'b0;
    logic        reset, ready;
    logic        lu_valid;
    logic [31:0] lu_pc;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_ctr;
    logic        up_valid, up_taken;
    logic [31:0] up_pc, up_target;
    logic [1:0]  up_ctr;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_vld [BTB_N];
    int unsigned m_tag [BTB_N];
    int unsigned m_tgt [BTB_N];
    int          m_ctr [BHT_N];

    // Expected outputs of the most recent accepted lookup
    bit          e_hit, e_taken;
    int unsigned e_tgt;
    int          e_ctr;

    bpred_btb_bimodal dut (
        .clk(clk), .reset(reset), .ready(ready),
        .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ctr(pred_ctr),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken),
        .up_target(up_target), .up_ctr(up_ctr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < BTB_N; i++) begin m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
        for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
        e_hit = 0; e_taken = 0; e_tgt = 0; e_ctr = 0;
    endfunction

    // One RUN cycle: optional update and optional lookup, checked one edge later
    task automatic do_cycle(input bit lv, input int unsigned lpc,
                            input bit uv, input int unsigned upc, input bit ut,
                            input int unsigned utgt, input int uc);
        int bi, hi;
        lu_valid = lv; lu_pc = lpc;
        up_valid = uv; up_pc = upc; up_taken = ut; up_target = utgt; up_ctr = uc[1:0];
        if (uv) begin
            hi = (upc >> 2) % BHT_N;
            m_ctr[hi] = ut ? ((uc >= 3) ? 3 : uc + 1) : ((uc <= 0) ? 0 : uc - 1);
            if (ut) begin
                bi = (upc >> 2) % BTB_N;
                m_vld[bi] = 1;
                m_tag[bi] = (upc >> 10) % (1 << TAGW);
                m_tgt[bi] = utgt & 32'hFFFF_FFFC;
            end
        end
        if (lv) begin
            bi = (lpc >> 2) % BTB_N;
            hi = (lpc >> 2) % BHT_N;
`ifdef BPRED_TAG_EN
            e_hit = m_vld[bi] && (m_tag[bi] == (lpc >> 10) % (1 << TAGW));
`else
            e_hit = m_vld[bi];
`endif
            e_ctr   = m_ctr[hi];
            e_taken = e_hit && (e_ctr >= 2);
            e_tgt   = m_tgt[bi];
        end
        step();
        lu_valid = 0; up_valid = 0;
        check("pred_valid", pred_valid, lv);
        check("pred_hit", pred_hit, e_hit);
        check("pred_taken", pred_taken, e_taken);
        check("pred_ctr", pred_ctr, e_ctr);
        if (e_hit) check("pred_target", pred_target, e_tgt);
    endtask

    task automatic do_reset();
        reset = 1; lu_valid = 0; up_valid = 0;
        step();
        reset = 0;
        model_clear();
        check("rst_ready", ready, 0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_hit", pred_hit, 0);
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_target", pred_target, 0);
        check("rst_pred_ctr", pred_ctr, 0);
    endtask

    // Random traffic during the clear must be ignored; ready after exactly 512 cycles
    task automatic wait_ready();
        int n, seen;
        n = 0; seen = 0;
        while (!ready && n < 2000) begin
            lu_valid = $urandom_range(0, 1); lu_pc = $urandom & 32'h0000_0FFC;
            up_valid = $urandom_range(0, 1); up_pc = $urandom & 32'h0000_0FFC;
            up_taken = 1; up_target = $urandom; up_ctr = 2'b10;
            step();
            if (pred_valid) seen++;
            n++;
        end
        lu_valid = 0; up_valid = 0;
        check("init_cycles", n, 512);
        check("init_pred_valid_seen", seen, 0);
    endtask

    initial begin
        reset = 0; lu_valid = 0; lu_pc = 0; up_valid = 0; up_pc = 0;
        up_taken = 0; up_target = 0; up_ctr = 0;
        model_clear();
        step();
        do_reset();
        wait_ready();

        // Directed scenarios
        do_cycle(1, 32'h100, 0, 0, 0, 0, 0);                // cold miss, ctr WNT
        do_cycle(0, 32'h100, 1, 32'h100, 1, 32'h200, 1);    // taken update, outputs hold
        do_cycle(1, 32'h100, 0, 0, 0, 0, 0);                // hit 0x200, ctr WT
        do_cycle(0, 0, 1, 32'h104, 1, 32'h444, 3);          // saturate high
        do_cycle(1, 32'h104, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 32'h108, 0, 32'h888, 0);          // saturate low
        do_cycle(1, 32'h108, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 32'h100, 0, 32'h999, 2);          // not-taken keeps BTB
        do_cycle(1, 32'h100, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h500, 0, 0, 0, 0, 0);                // alias on BTB index
        do_cycle(1, 32'h100, 1, 32'h100, 1, 32'h300, 2);    // same-cycle bypass
        check("bypass_target", pred_target, 32'h300);
        check("bypass_ctr", pred_ctr, 2'b11);

        // Randomized traffic over a small PC pool to force index and tag sharing
        for (int k = 0; k < 400; k++) begin
            int unsigned lp, up;
            lp = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
            up = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 3) == 0) up = lp;
            do_cycle($urandom_range(0, 9) < 7, lp, $urandom_range(0, 1), up,
                     $urandom_range(0, 1), $urandom, $urandom_range(0, 3));
        end

        // Reset partway through the clear must restart it from scratch
        do_reset();
        for (int k = 0; k < 100; k++) begin
            up_valid = 1; up_pc = k * 4; up_taken = 1; up_target = 32'h7000; up_ctr = 3;
            step();
        end
        up_valid = 0;
        do_reset();
        wait_ready();
        do_cycle(1, 32'h100, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h104, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h500, 0, 0, 0, 0, 0);
        do_cycle(1, 32'h40, 0, 0, 0, 0, 0);
        check("post_reset_ctr", pred_ctr, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
